i2c_slave_responder: RTL and testbench
======================================

I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 The module SHALL take one parameter: SLAVE_ADDR, default 7'h18, the 7-bit device address it answers to.
REQ-002 The module SHALL have one clock, i2c_clk, and one reset, RSTn; RSTn SHALL be asynchronous and active-low.
REQ-003 Port i2c_clk: input, 1 bit, oversampling clock, at least 8x the SCL frequency.
REQ-004 Port RSTn: input, 1 bit, asynchronous active-low reset.
REQ-005 Port I2C_SCLK: input, 1 bit, bus clock driven by the master.
REQ-006 Port I2C_SDAT: inout, 1 bit, open-drain data line; the module drives only 0 or z.
REQ-007 Port reg_addr: output, 8 bits, current register pointer.
REQ-008 Port reg_wr: output, 1 bit, one-cycle write strobe.
REQ-009 Port reg_wdata: output, 8 bits, data byte qualified by reg_wr.
REQ-010 Port reg_rdata: input, 8 bits, register bank contents at reg_addr; combinational, valid in the same cycle.
REQ-011 Port busy: output, 1 bit, high from an addressed START until STOP or NACK.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer plus an edge register; all decisions SHALL use the synchronized values only.
REQ-013 START SHALL be detected when synchronized SDA falls while SCL is high; STOP when SDA rises while SCL is high.
REQ-014 START SHALL override every state, including a repeated START mid-transfer; the FSM SHALL go to ADDR with the bit counter at 7.
REQ-015 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-016 Data SHALL be sampled MSB-first on each SCL rising edge.
REQ-017 When driving, the module SHALL change SDA exactly one i2c_clk after the synchronized SCL falling edge.
REQ-018 ADDR, after 8 bits, when addr[7:1]==SLAVE_ADDR: the module SHALL drive ACK (SDA=0) for one SCL period.
REQ-019 After that ACK, the FSM SHALL go to READ if R/W=1, or to REG if R/W=0.
REQ-020 ADDR mismatch: the module SHALL leave SDA at z, keep busy low, and go to WAIT_STOP.
REQ-021 REG: the 8 sampled bits SHALL load reg_addr, then REG_ACK drives ACK, then the FSM goes to WRITE.
REQ-022 WRITE: after 8 bits, reg_wdata SHALL be loaded and reg_wr pulsed for exactly one i2c_clk on the 8th SCL rising edge + 1 cycle.
REQ-023 WRITE_ACK drives ACK; reg_addr SHALL increment at the ACK SCL falling edge, and the FSM returns to WRITE.
REQ-024 READ: on entry, a shift register SHALL load reg_rdata at the SCL falling edge ending the previous ACK, then drive bits MSB-first with 1 as z and 0 as 0.
REQ-025 READ_ACK: SDA SHALL be released and the master bit sampled; on ACK (0) reg_addr increments and the FSM returns to READ with fresh reg_rdata.
REQ-026 READ_ACK: on NACK (1) the FSM SHALL go to WAIT_STOP with no increment.
REQ-027 reg_addr SHALL wrap from 8'hFF to 8'h00.
REQ-028 STOP SHALL force IDLE from any state, release SDA, and drop busy within 1 cycle.
REQ-029 The module SHALL never hold SCL low; clock stretching is not supported.

Reset
REQ-030 While RSTn=0: state IDLE, SDA z, reg_wr 0, reg_wdata 8'h00, reg_addr 8'h00, busy 0, synchronizers 1.
REQ-031 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after release, the module SHALL ignore the bus until the next START.

Structure
REQ-032 Shared package i2c_pkg SHALL hold the FSM state encodings (4-bit), the ACK/NACK constants, and the default slave address 7'h18.
REQ-033 The synchronizer + edge detector SHALL be a sub-module i2c_edge_sync, instantiated once for SCL and once for SDA, with outputs level, rise, fall.

Verification
REQ-034 Write: START, 0x30, 0x0F, 0x03, STOP -> three ACKs, one reg_wr with reg_wdata=0x03 and reg_addr=0x0F, busy low after STOP.
REQ-035 Burst write: 0x30, 0xFE, 0xAA, 0xBB, 0xCC -> writes at 0xFE, 0xFF, 0x00 (wrap), final reg_addr=0x01.
REQ-036 Read: 0x30, 0x13, repeated START, 0x31, master reads with reg_rdata=0x5A then NACK -> bus returns 0x5A, reg_addr stays 0x13, WAIT_STOP then IDLE.
REQ-037 Foreign address: START 0xA0 -> SDA never driven, busy 0, no reg_wr, ignored until STOP.
REQ-038 RSTn pulled low during a read data bit that is driving 0 -> SDA z within the same cycle; the next full write transaction completes correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM state encoding, ACK/NACK bus levels
// and the default 7-bit device address.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WRITE     = 4'd5,
    WRITE_ACK = 4'd6,
    READ      = 4'd7,
    READ_ACK  = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  localparam logic       ACK            = 1'b0;
  localparam logic       NACK           = 1'b1;
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h18;

endpackage

// File: rtl/i2c_edge_sync.sv
// Two-flop synchronizer plus edge register for one bus line.
// Ports: clk, rst_n (async, low), din -> level, rise, fall (1-cycle pulses).
`timescale 1ns/1ps
module i2c_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  // Idle bus is high, so everything resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave exposing an 8-bit register pointer with auto-increment.
// Ports: i2c_clk, RSTn, I2C_SCLK, I2C_SDAT (open drain), reg_addr,
//        reg_wr, reg_wdata, reg_rdata (comb. bank data), busy.
`timescale 1ns/1ps
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR
) (
  input  logic       i2c_clk,
  input  logic       RSTn,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] addr_n, wdata_n;
  logic       oe, oe_n;
  logic       wr_n, busy_n;
  logic       rw, rw_n;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start, stop;

  i2c_edge_sync u_scl (
    .clk   (i2c_clk),
    .rst_n (RSTn),
    .din   (I2C_SCLK),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_edge_sync u_sda (
    .clk   (i2c_clk),
    .rst_n (RSTn),
    .din   (I2C_SDAT),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  // oe is a flop with async clear, so reset frees the line at once.
  assign I2C_SDAT = oe ? 1'b0 : 1'bz;

  always_ff @(posedge i2c_clk or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge i2c_clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt       <= 3'd0;
      shift     <= 8'h00;
      oe        <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_wr    <= 1'b0;
      busy      <= 1'b0;
      rw        <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      shift     <= shift_n;
      oe        <= oe_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_wr    <= wr_n;
      busy      <= busy_n;
      rw        <= rw_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    oe_n    = oe;
    addr_n  = reg_addr;
    wdata_n = reg_wdata;
    wr_n    = 1'b0;
    busy_n  = busy;
    rw_n    = rw;
    if (start) begin
      state_n = ADDR;
      cnt_n   = 3'd7;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR, REG, WRITE: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda};
            cnt_n   = cnt - 3'd1;
            if (cnt == 3'd0) begin
              unique case (state)
                ADDR: begin
                  rw_n = sda;
                  if (shift[6:0] == SLAVE_ADDR) begin
                    busy_n  = 1'b1;
                    state_n = ADDR_ACK;
                  end else begin
                    state_n = WAIT_STOP;
                  end
                end
                REG: begin
                  addr_n  = {shift[6:0], sda};
                  state_n = REG_ACK;
                end
                default: begin
                  wdata_n = {shift[6:0], sda};
                  wr_n    = 1'b1;
                  state_n = WRITE_ACK;
                end
              endcase
            end
          end
        end
        // oe doubles as the phase flag: first fall drives ACK,
        // second fall ends the ACK bit.
        ADDR_ACK, REG_ACK, WRITE_ACK: begin
          if (scl_fall) begin
            oe_n  = ~oe;
            cnt_n = 3'd7;
            if (oe) begin
              if (state == WRITE_ACK) addr_n = reg_addr + 8'd1;
              if (state == ADDR_ACK && rw) begin
                state_n = READ;
                shift_n = reg_rdata;
                oe_n    = ~reg_rdata[7];
              end else if (state == ADDR_ACK) begin
                state_n = REG;
              end else begin
                state_n = WRITE;
              end
            end
          end
        end
        READ: begin
          if (scl_fall) begin
            if (cnt == 3'd0) begin
              oe_n    = 1'b0;
              cnt_n   = 3'd1;
              state_n = READ_ACK;
            end else begin
              cnt_n   = cnt - 3'd1;
              shift_n = {shift[6:0], shift[7]};
              oe_n    = ~shift[6];
            end
          end
        end
        // cnt=1: waiting for master bit; cnt=0: ACKed, reload on fall.
        // Pointer moves on the rise so reg_rdata is fresh by the fall.
        READ_ACK: begin
          if (scl_rise && cnt != 3'd0) begin
            if (sda == ACK) begin
              addr_n = reg_addr + 8'd1;
              cnt_n  = 3'd0;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && cnt == 3'd0) begin
            state_n = READ;
            cnt_n   = 3'd7;
            shift_n = reg_rdata;
            oe_n    = ~reg_rdata[7];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench for i2c_slave_responder: bus-level master tasks,
// fixed random register bank, reference pointer/write-log model.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam int Q = 40;

  logic       i2c_clk = 1'b0;
  logic       RSTn = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_line;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, busy;

  logic [7:0]  mem [256];
  logic [15:0] wr_log [1024];
  int          wr_cnt = 0;
  int          dut_low_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model_ptr = 8'h00;

  always #5 i2c_clk = ~i2c_clk;

  assign sda_line = m_low ? 1'b0 : 1'bz;
  pullup (sda_line);
  assign reg_rdata = mem[reg_addr];

  i2c_slave_responder dut (
    .i2c_clk   (i2c_clk),
    .RSTn      (RSTn),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda_line),
    .reg_addr  (reg_addr),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(negedge i2c_clk) begin
    if (reg_wr && wr_cnt < 1024) begin
      wr_log[wr_cnt] <= {reg_addr, reg_wdata};
      wr_cnt <= wr_cnt + 1;
    end
    if (sda_line === 1'b0 && !m_low) dut_low_cnt <= dut_low_cnt + 1;
  end

  task automatic bit_cycle(input logic one, output logic smp);
    m_low = !one;
    #Q scl = 1'b1;
    #Q smp = sda_line;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  task automatic bus_start;
    m_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_rstart;
    m_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop;
    m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #Q;
    #Q;
  endtask

  task automatic do_write(input logic [7:0] ra, input logic [31:0] dw,
                          input int n, output int nacks);
    logic a;
    nacks = 0;
    bus_start;
    send_byte(8'h30, a); nacks += int'(a);
    send_byte(ra, a);    nacks += int'(a);
    for (int k = 0; k < n; k++) begin
      send_byte(dw[8*k +: 8], a);
      nacks += int'(a);
    end
    bus_stop;
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] ra,
                         input int n, output logic [31:0] got,
                         output int nacks);
    logic a;
    logic [7:0] b;
    nacks = 0;
    got = 32'h0;
    bus_start;
    if (set_ptr) begin
      send_byte(8'h30, a); nacks += int'(a);
      send_byte(ra, a);    nacks += int'(a);
      bus_rstart;
    end
    send_byte(8'h31, a); nacks += int'(a);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      got[8*k +: 8] = b;
    end
    bus_stop;
  endtask

  task automatic check_writes(input string nm, input int base,
                              input logic [7:0] a0, input logic [31:0] dw,
                              input int n);
    logic [15:0] exp;
    checks++;
    if (wr_cnt - base !== n) begin
      failures++;
      $display("FAIL %s wr_count: got %0d expected %0d", nm, wr_cnt - base, n);
    end else begin
      for (int k = 0; k < n; k++) begin
        exp = {a0 + 8'(k), dw[8*k +: 8]};
        checks++;
        if (wr_log[base + k] !== exp) begin
          failures++;
          $display("FAIL %s wr[%0d]: got %h expected %h", nm, k, wr_log[base + k], exp);
        end
      end
    end
  endtask

  task automatic test_reset;
    #32;
    checks++;
    if ({busy, reg_wr, reg_addr, reg_wdata, sda_line} !== 19'h00001) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h",
               {busy, reg_wr, reg_addr, reg_wdata, sda_line}, 19'h00001);
    end
    RSTn = 1'b1;
    #50;
    checks++;
    if ({busy, reg_wr, reg_addr, reg_wdata, sda_line} !== 19'h00001) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h",
               {busy, reg_wr, reg_addr, reg_wdata, sda_line}, 19'h00001);
    end
  endtask

  task automatic test_write;
    logic a0, a1, a2;
    int base;
    base = wr_cnt;
    bus_start;
    send_byte(8'h30, a0);
    send_byte(8'h0F, a1);
    send_byte(8'h03, a2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL write_busy: got %b expected 1", busy);
    end
    bus_stop;
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      failures++;
      $display("FAIL write_acks: got %b expected 000", {a0, a1, a2});
    end
    check_writes("write", base, 8'h0F, 32'h03, 1);
    model_ptr = 8'h10;
    checks++;
    if ({busy, reg_addr} !== {1'b0, model_ptr}) begin
      failures++;
      $display("FAIL write_end: got %h expected %h", {busy, reg_addr}, {1'b0, model_ptr});
    end
  endtask

  task automatic test_burst_wrap;
    int base, nk;
    base = wr_cnt;
    do_write(8'hFE, 32'h00CCBBAA, 3, nk);
    checks++;
    if (nk !== 0) begin
      failures++;
      $display("FAIL burst_acks: got %0d nacks expected 0", nk);
    end
    check_writes("burst", base, 8'hFE, 32'h00CCBBAA, 3);
    model_ptr = 8'h01;
    checks++;
    if (reg_addr !== model_ptr) begin
      failures++;
      $display("FAIL burst_ptr: got %h expected %h", reg_addr, model_ptr);
    end
  endtask

  task automatic test_read;
    logic a0, a1, a2;
    logic [7:0] b;
    bus_start;
    send_byte(8'h30, a0);
    send_byte(8'h13, a1);
    bus_rstart;
    send_byte(8'h31, a2);
    recv_byte(1'b1, b);
    checks++;
    if ({busy, reg_addr} !== {1'b0, 8'h13}) begin
      failures++;
      $display("FAIL read_nack_state: got %h expected %h", {busy, reg_addr}, {1'b0, 8'h13});
    end
    bus_stop;
    model_ptr = 8'h13;
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      failures++;
      $display("FAIL read_acks: got %b expected 000", {a0, a1, a2});
    end
    checks++;
    if (b !== 8'h5A) begin
      failures++;
      $display("FAIL read_data: got %h expected 5a", b);
    end
    checks++;
    if ({busy, reg_addr} !== {1'b0, model_ptr}) begin
      failures++;
      $display("FAIL read_end: got %h expected %h", {busy, reg_addr}, {1'b0, model_ptr});
    end
  endtask

  task automatic test_foreign;
    logic a, x;
    int base, lowb;
    base = wr_cnt;
    lowb = dut_low_cnt;
    bus_start;
    send_byte(8'hA0, a);
    send_byte(8'h0F, x);
    send_byte(8'h55, x);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL foreign_busy: got %b expected 0", busy);
    end
    bus_stop;
    checks++;
    if (a !== 1'b1) begin
      failures++;
      $display("FAIL foreign_ack: got %b expected 1", a);
    end
    checks++;
    if (dut_low_cnt - lowb !== 0) begin
      failures++;
      $display("FAIL foreign_sda: got %0d driven cycles expected 0", dut_low_cnt - lowb);
    end
    checks++;
    if ({wr_cnt - base, 24'(reg_addr)} !== {32'd0, 24'(model_ptr)}) begin
      failures++;
      $display("FAIL foreign_regs: got writes %0d ptr %h expected 0 ptr %h",
               wr_cnt - base, reg_addr, model_ptr);
    end
  endtask

  task automatic test_reset_mid_read;
    logic a, s;
    logic [7:0] b;
    int base, nk;
    bus_start;
    send_byte(8'h30, a);
    send_byte(8'h40, a);
    bus_rstart;
    send_byte(8'h31, a);
    m_low = 1'b0;
    #Q scl = 1'b1;
    #Q;
    checks++;
    if (sda_line !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drive: got %b expected 0", sda_line);
    end
    RSTn = 1'b0;
    #1;
    checks++;
    if ({sda_line, busy} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_release: got %b expected 10", {sda_line, busy});
    end
    #(Q - 1) scl = 1'b0;
    #Q RSTn = 1'b1;
    #Q;
    // leftover master clocks of the dead read must be ignored
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
    bus_stop;
    model_ptr = 8'h00;
    checks++;
    if (reg_addr !== model_ptr) begin
      failures++;
      $display("FAIL rstmid_ptr: got %h expected %h", reg_addr, model_ptr);
    end
    base = wr_cnt;
    do_write(8'h21, 32'h77, 1, nk);
    checks++;
    if (nk !== 0) begin
      failures++;
      $display("FAIL rstmid_acks: got %0d nacks expected 0", nk);
    end
    check_writes("rstmid", base, 8'h21, 32'h77, 1);
    model_ptr = 8'h22;
    checks++;
    if (reg_addr !== model_ptr) begin
      failures++;
      $display("FAIL rstmid_end: got %h expected %h", reg_addr, model_ptr);
    end
    b = 8'h00;
  endtask

  task automatic test_random;
    int kind, n, nk, base;
    logic [7:0] ra;
    logic [31:0] dw, got, exp;
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      ra = 8'($urandom);
      dw = $urandom;
      base = wr_cnt;
      exp = 32'h0;
      if (kind == 0) begin
        do_write(ra, dw, n, nk);
        check_writes("rnd_write", base, ra, dw, n);
        model_ptr = ra + 8'(n);
      end else begin
        do_read(kind == 1, ra, n, got, nk);
        if (kind == 1) model_ptr = ra;
        for (int k = 0; k < n; k++) exp[8*k +: 8] = mem[model_ptr + 8'(k)];
        model_ptr = model_ptr + 8'(n - 1);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rnd_read it%0d: got %h expected %h", it, got, exp);
        end
        checks++;
        if (wr_cnt !== base) begin
          failures++;
          $display("FAIL rnd_read_nowr it%0d: got %0d writes expected 0", it, wr_cnt - base);
        end
      end
      checks++;
      if (nk !== 0) begin
        failures++;
        $display("FAIL rnd_acks it%0d: got %0d nacks expected 0", it, nk);
      end
      checks++;
      if ({busy, reg_addr} !== {1'b0, model_ptr}) begin
        failures++;
        $display("FAIL rnd_ptr it%0d: got %h expected %h", it, {busy, reg_addr}, {1'b0, model_ptr});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h13] = 8'h5A;
    mem[8'h40] = 8'h3C;
    #2;
    test_reset;
    test_write;
    test_burst_wrap;
    test_read;
    test_foreign;
    test_reset_mid_read;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
